// File: rtl/xpr_array_ctrl.sv
// Sequencer for an array of XPR entropy slices: repeated quiet/settle/sample evaluations with per-slice majority vote.
// Optional XPR_ARRAY_STABILITY_MASK_EN adds resp_unstable, flagging slices whose votes were not unanimous.
module xpr_array_ctrl #(
  parameter int N_SLICES      = 8,
  parameter int N_REPEAT      = 5,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2*N_SLICES-1:0] challenge,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [N_SLICES-1:0]   resp_data,
`ifdef XPR_ARRAY_STABILITY_MASK_EN
  output logic [N_SLICES-1:0]   resp_unstable,
`endif
  output logic                  slice_ir,
  output logic [N_SLICES-1:0]   slice_i1,
  output logic [N_SLICES-1:0]   slice_i2,
  input  logic [N_SLICES-1:0]   slice_out1,
  input  logic [N_SLICES-1:0]   slice_out2
);

  // state  | meaning
  // IDLE   | waiting for a challenge, req_ready high
  // QUIET  | 2 cycles, slices held low
  // SETTLE | SETTLE_CYCLES cycles, slices released
  // SAMPLE | 1 cycle, synchronised XOR folded into votes
  // DONE   | response presented until consumed
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] QUIET  = 3'd1;
  localparam logic [2:0] SETTLE = 3'd2;
  localparam logic [2:0] SAMPLE = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  localparam int VW = $clog2(N_REPEAT + 1);

  logic [2:0]          state;
  logic [7:0]          timer;
  logic [VW-1:0]       eval_cnt;
  logic [VW-1:0]       vote [N_SLICES];
  logic [N_SLICES-1:0] s1_a, s1_b, s2_a, s2_b;
  logic [N_SLICES-1:0] raw, maj;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_a <= '0;
      s1_b <= '0;
      s2_a <= '0;
      s2_b <= '0;
    end else begin
      s1_a <= slice_out1;
      s1_b <= s1_a;
      s2_a <= slice_out2;
      s2_b <= s2_a;
    end
  end

  assign raw       = s1_b ^ s2_b;
  assign req_ready = (state == IDLE);

  always_comb begin
    maj = '0;
    for (int i = 0; i < N_SLICES; i++)
      maj[i] = (vote[i] > VW'(N_REPEAT / 2));
  end

`ifdef XPR_ARRAY_STABILITY_MASK_EN
  logic [N_SLICES-1:0] unst;
  always_comb begin
    unst = '0;
    for (int i = 0; i < N_SLICES; i++)
      unst[i] = (vote[i] != '0) && (vote[i] != VW'(N_REPEAT));
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      timer      <= '0;
      eval_cnt   <= '0;
      slice_ir   <= 1'b0;
      slice_i1   <= '0;
      slice_i2   <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
`ifdef XPR_ARRAY_STABILITY_MASK_EN
      resp_unstable <= '0;
`endif
      for (int i = 0; i < N_SLICES; i++) vote[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            for (int i = 0; i < N_SLICES; i++) begin
              slice_i1[i] <= challenge[2*i];
              slice_i2[i] <= challenge[2*i+1];
            end
            timer <= 8'd1;
            state <= QUIET;
          end
        end
        QUIET: begin
          if (timer == 8'd0) begin
            timer    <= 8'(SETTLE_CYCLES - 1);
            slice_ir <= 1'b1;
            state    <= SETTLE;
          end else begin
            timer <= timer - 8'd1;
          end
        end
        SETTLE: begin
          if (timer == 8'd0) state <= SAMPLE;
          else               timer <= timer - 8'd1;
        end
        SAMPLE: begin
          for (int i = 0; i < N_SLICES; i++) vote[i] <= vote[i] + VW'(raw[i]);
          slice_ir <= 1'b0;
          if (eval_cnt == VW'(N_REPEAT - 1)) begin
            eval_cnt <= '0;
            state    <= DONE;
          end else begin
            eval_cnt <= eval_cnt + 1'b1;
            timer    <= 8'd1;
            state    <= QUIET;
          end
        end
        DONE: begin
          // Votes include the last sample only from here, so the response registers one cycle in.
          if (!resp_valid) begin
            resp_valid <= 1'b1;
            resp_data  <= maj;
`ifdef XPR_ARRAY_STABILITY_MASK_EN
            resp_unstable <= unst;
`endif
          end else if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
            for (int i = 0; i < N_SLICES; i++) vote[i] <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
